frontend_link_tx: RTL and testbench

FRONTEND_LINK_TX -- requirements
Module: frontend_link_tx

---
 rtl/frontend_link_tx.sv | 218 +++++++++++++++++++++
 tb/tb_frontend_link_tx.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/frontend_link_tx.sv
`default_nettype none
// ============================================================================
// Module      : frontend_link_tx
// Description : Multi-line serial frame transmitter. Payload words are queued
//               in a DEPTH-entry FIFO, split into LINES slices of
//               ceil(LENGTH/LINES) bits, and sent MSB first on every line in
//               lock-step frames: start 0, data bits, optional even parity,
//               stop 1. Lines idle high.
//               Build option: define FRONTEND_LINK_TX_PARITY_EN to insert the
//               parity bit into every frame.
// Revision    : 1.0 - initial release
// ============================================================================
module frontend_link_tx #(
    parameter int LINES  = 3,
    parameter int LENGTH = 128,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [LENGTH-1:0] data_in,
    input  logic              valid,
    output logic              ready,
    output logic [LINES-1:0]  d,
    output logic              idle,
    output logic [15:0]       frame_count
);

    localparam int c_slice_w = (LENGTH + LINES - 1) / LINES;
    localparam int c_pad_w   = LINES * c_slice_w;
    localparam int c_ptr_w   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_cnt_w   = $clog2(DEPTH) + 1;
    localparam int c_bit_w   = (c_slice_w > 1) ? $clog2(c_slice_w) : 1;

    localparam logic [c_bit_w-1:0] c_last_bit = c_bit_w'(c_slice_w - 1);
    localparam logic [c_cnt_w-1:0] c_full     = c_cnt_w'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                          state_q, state_d;
    logic [LENGTH-1:0]               mem_q [DEPTH];
    logic [c_ptr_w-1:0]              wr_ptr_q, wr_ptr_d;
    logic [c_ptr_w-1:0]              rd_ptr_q, rd_ptr_d;
    logic [c_cnt_w-1:0]              count_q, count_d;
    logic [LINES-1:0][c_slice_w-1:0] shreg_q, shreg_d;
    logic [c_bit_w-1:0]              bit_q, bit_d;
    logic [LINES-1:0]                d_q, d_d;
    logic                            ready_q, ready_d;
    logic                            idle_q, idle_d;
    logic [15:0]                     frame_count_q, frame_count_d;
`ifdef FRONTEND_LINK_TX_PARITY_EN
    logic [LINES-1:0]                parity_q, parity_d;
`endif

    logic                            w_push;
    logic                            w_pop;
    logic                            w_empty;
    logic [c_pad_w-1:0]              w_pad;

    // ready is a registered not-full flag, so acceptance never depends on valid
    assign w_push  = valid & ready_q;
    assign w_empty = (count_q == '0);
    // head word zero-extended to a whole number of slices
    assign w_pad   = c_pad_w'(mem_q[rd_ptr_q]);

    // FIFO storage; pointers carry the flush, contents are cleared for determinism
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (w_push) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    // next-state, shift register, FIFO bookkeeping and registered outputs
    always_comb begin
        state_d       = state_q;
        bit_d         = bit_q;
        shreg_d       = shreg_q;
        frame_count_d = frame_count_q;
        w_pop         = 1'b0;
`ifdef FRONTEND_LINK_TX_PARITY_EN
        parity_d      = parity_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (!w_empty) begin
                    state_d = S_START;
                    w_pop   = 1'b1;
                end
            end
            S_START: begin
                state_d = S_DATA;
                bit_d   = '0;
            end
            S_DATA: begin
                if (bit_q == c_last_bit) begin
`ifdef FRONTEND_LINK_TX_PARITY_EN
                    state_d = S_PARITY;
`else
                    state_d = S_STOP;
`endif
                end else begin
                    bit_d = bit_q + c_bit_w'(1);
                end
            end
            S_PARITY: begin
                state_d = S_STOP;
            end
            S_STOP: begin
                frame_count_d = frame_count_q + 16'd1;
                if (!w_empty) begin
                    state_d = S_START;
                    w_pop   = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // popping the head loads all slices (and their parities) at once
        if (w_pop) begin
            for (int j = 0; j < LINES; j++) begin
                shreg_d[j] = w_pad[j*c_slice_w +: c_slice_w];
`ifdef FRONTEND_LINK_TX_PARITY_EN
                parity_d[j] = ^w_pad[j*c_slice_w +: c_slice_w];
`endif
            end
        end

        // line value is registered alongside the state it belongs to
        d_d = '1;
        case (state_d)
            S_START: begin
                d_d = '0;
            end
            S_DATA: begin
                for (int j = 0; j < LINES; j++) begin
                    d_d[j]     = shreg_q[j][c_slice_w-1];
                    shreg_d[j] = shreg_q[j] << 1;
                end
            end
            S_PARITY: begin
`ifdef FRONTEND_LINK_TX_PARITY_EN
                d_d = parity_q;
`else
                d_d = '1;
`endif
            end
            default: begin
                d_d = '1;
            end
        endcase

        wr_ptr_d = w_push ? wr_ptr_q + c_ptr_w'(1) : wr_ptr_q;
        rd_ptr_d = w_pop  ? rd_ptr_q + c_ptr_w'(1) : rd_ptr_q;
        count_d  = count_q;
        if (w_push && !w_pop) begin
            count_d = count_q + c_cnt_w'(1);
        end else if (!w_push && w_pop) begin
            count_d = count_q - c_cnt_w'(1);
        end

        ready_d = (count_d != c_full);
        idle_d  = (state_d == S_IDLE) && (count_d == '0);
    end

    // state and datapath registers; reset forces the line idle immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            shreg_q       <= '0;
            bit_q         <= '0;
            d_q           <= '1;
            ready_q       <= 1'b0;
            idle_q        <= 1'b1;
            frame_count_q <= '0;
`ifdef FRONTEND_LINK_TX_PARITY_EN
            parity_q      <= '0;
`endif
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            shreg_q       <= shreg_d;
            bit_q         <= bit_d;
            d_q           <= d_d;
            ready_q       <= ready_d;
            idle_q        <= idle_d;
            frame_count_q <= frame_count_d;
`ifdef FRONTEND_LINK_TX_PARITY_EN
            parity_q      <= parity_d;
`endif
        end
    end

    assign ready       = ready_q;
    assign d           = d_q;
    assign idle        = idle_q;
    assign frame_count = frame_count_q;

endmodule
`default_nettype wire

// File: tb/tb_frontend_link_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_frontend_link_tx
// Description : Scoreboard bench for frontend_link_tx. Accepted words are
//               queued; a line monitor rebuilds every frame and compares it
//               with the queue head. Honours FRONTEND_LINK_TX_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frontend_link_tx;

    localparam int LINES  = 3;
    localparam int LENGTH = 128;
    localparam int DEPTH  = 4;
    localparam int c_w    = (LENGTH + LINES - 1) / LINES;
`ifdef FRONTEND_LINK_TX_PARITY_EN
    localparam int c_frame = c_w + 3;
`else
    localparam int c_frame = c_w + 2;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [LENGTH-1:0] data_in = '0;
    logic              valid = 1'b0;
    logic              ready;
    logic [LINES-1:0]  d;
    logic              idle;
    logic [15:0]       frame_count;

    int                n_checks = 0;
    int                n_errors = 0;
    int                cyc = 0;
    int                mpos = -1;
    int                n_frames = 0;
    logic [15:0]       exp_fc = '0;
    logic [LENGTH-1:0] exp_q[$];
    int                start_cyc[$];
    int                stop_cyc[$];

    logic [LINES-1:0][c_w-1:0] cap;
    logic [LINES-1:0]          cap_par;
    logic [LINES*c_w-1:0]      ep;
    logic [LINES-1:0]          pe;
    logic [LENGTH-1:0]         hw;

    frontend_link_tx #(
        .LINES  (LINES),
        .LENGTH (LENGTH),
        .DEPTH  (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .data_in     (data_in),
        .valid       (valid),
        .ready       (ready),
        .d           (d),
        .idle        (idle),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // line monitor: rebuilds each frame and scores it against the queue head
    always @(negedge clk) begin
        if (rst) begin
            mpos = -1;
        end else if (mpos < 0) begin
            if (d == '0) begin
                mpos = 0;
                n_frames++;
                start_cyc.push_back(cyc);
            end else begin
                check("idle_line", 256'(d), 256'({LINES{1'b1}}));
            end
        end else begin
            mpos++;
            if (mpos <= c_w) begin
                for (int j = 0; j < LINES; j++) begin
                    cap[j] = (cap[j] << 1) | c_w'(d[j]);
                end
`ifdef FRONTEND_LINK_TX_PARITY_EN
            end else if (mpos == c_w + 1) begin
                cap_par = d;
`endif
            end else begin
                check("stop_bit", 256'(d), 256'({LINES{1'b1}}));
                stop_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", 256'(1), 256'(0));
                end else begin
                    hw = exp_q.pop_front();
                    ep = '0;
                    ep[LENGTH-1:0] = hw;
                    for (int j = 0; j < LINES; j++) begin
                        pe[j] = ^ep[j*c_w +: c_w];
                    end
                    check("frame_data", 256'(cap), 256'(ep));
`ifdef FRONTEND_LINK_TX_PARITY_EN
                    check("parity", 256'(cap_par), 256'(pe));
`endif
                end
                exp_fc = exp_fc + 16'd1;
                mpos = -1;
            end
        end
    end

    task automatic send(input logic [LENGTH-1:0] w);
        int n;
        n = 0;
        @(negedge clk);
        data_in = w;
        valid   = 1'b1;
        while (!ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!ready) begin
            check("send_timeout", 256'(0), 256'(1));
        end else begin
            exp_q.push_back(w);
            @(posedge clk);
        end
        #1 valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(idle && mpos < 0 && exp_q.size() == 0) && n < 3000);
        if (n >= 3000) check("idle_timeout", 256'(0), 256'(1));
        else check("frame_count", 256'(frame_count), 256'(exp_fc));
    endtask

    task automatic check_train(input int nf);
        check("train_frames", 256'(stop_cyc.size()), 256'(nf));
        if (stop_cyc.size() == nf && start_cyc.size() == nf) begin
            check("train_span", 256'(stop_cyc[nf-1] - start_cyc[0] + 1), 256'(nf * c_frame));
            for (int i = 1; i < nf; i++) begin
                check("train_gap", 256'(start_cyc[i] - stop_cyc[i-1]), 256'(1));
            end
        end
        start_cyc.delete();
        stop_cyc.delete();
    endtask

    function automatic logic [LENGTH-1:0] rand_word();
        logic [255:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom(),
             $urandom(), $urandom(), $urandom(), $urandom()};
        return r[LENGTH-1:0];
    endfunction

    initial begin
        int n;
        int snap;
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_d", 256'(d), 256'({LINES{1'b1}}));
        check("rst_idle", 256'(idle), 256'(1));
        check("rst_ready", 256'(ready), 256'(0));
        check("rst_fc", 256'(frame_count), 256'(0));
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 256'(ready), 256'(1));

        // single word 1: start-bit latency, then full frame
        start_cyc.delete();
        stop_cyc.delete();
        send(LENGTH'(1));
        @(negedge clk);
        check("lat_hold", 256'(d), 256'({LINES{1'b1}}));
        @(negedge clk);
        check("lat_start", 256'(d), 256'(0));
        wait_idle();
        check_train(1);

        // all ones exercises the zero pad bit on the top line
        send('1);
        wait_idle();
        check_train(1);

        for (int k = 0; k < 3; k++) begin
            send(rand_word());
            wait_idle();
            check_train(1);
        end

        // five back-to-back words fill the FIFO behind the active frame
        for (int k = 0; k < 5; k++) begin
            send(rand_word());
        end
        @(negedge clk);
        check("burst_full", 256'(ready), 256'(0));
        wait_idle();
        check_train(5);

        // reset mid-frame with two words buffered
        send(rand_word());
        send(rand_word());
        send(rand_word());
        n = 0;
        while (mpos != 20 && n < 500) begin
            @(posedge clk);
            n++;
        end
        if (mpos != 20) check("rst_wait", 256'(0), 256'(1));
        #2 rst = 1'b1;
        #1;
        check("abort_d", 256'(d), 256'({LINES{1'b1}}));
        check("abort_idle", 256'(idle), 256'(1));
        check("abort_ready", 256'(ready), 256'(0));
        check("abort_fc", 256'(frame_count), 256'(0));
        exp_q.delete();
        exp_fc = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        snap = n_frames;
        repeat (150) @(negedge clk);
        check("post_rst_frames", 256'(n_frames), 256'(snap));
        check("post_rst_idle", 256'(idle), 256'(1));
        check("post_rst_fc", 256'(frame_count), 256'(0));
        check("post_rst_ready", 256'(ready), 256'(1));
        start_cyc.delete();
        stop_cyc.delete();

        // frame counter wrap from 0xFFFF
        @(negedge clk);
        force dut.frame_count_q = 16'hFFFF;
        exp_fc = 16'hFFFF;
        @(posedge clk);
        #1 release dut.frame_count_q;
        send(rand_word());
        wait_idle();
        check("fc_wrap", 256'(frame_count), 256'(0));
        check_train(1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
